// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion used by both pointer blocks.
// Functions work on a fixed wide vector; callers zero-extend in and size-cast out.
package fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 4;
   localparam int FIFO_FN_WIDTH   = 32;

   typedef logic [FIFO_FN_WIDTH-1:0] fifo_vec_t;

   function automatic fifo_vec_t bin2gray(input fifo_vec_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits stay zero, so a narrower pointer converts correctly once cast back.
   function automatic fifo_vec_t gray2bin(input fifo_vec_t g);
      fifo_vec_t b;
      b = '0;
      b[FIFO_FN_WIDTH-1] = g[FIFO_FN_WIDTH-1];
      for (int i = FIFO_FN_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus; 2 clk edges of latency, no backpressure.
// Async active-high reset clears both stages.
module sync_2ff #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1 <= '0;
         q  <= '0;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer, full/almost-full, conservative level and sticky overflow.
// Full asserts on the filling write; read progress frees space 3 edges later; writes while full are dropped.
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int AF_MARGIN  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  clr_overflow,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow
);

   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rq2;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] full_cmp;
   logic [PW-1:0] level_next;
   logic          wr_acc;
   logic          full_next;
   logic          af_next;

   sync_2ff #(.WIDTH(PW)) u_rptr_sync (
      .clk (clk),
      .rst (rst),
      .d   (rd_ptr_gray),
      .q   (rq2)
   );

   // Accept decision uses the registered full so no input reaches an output combinationally.
   always_comb begin
      wr_acc     = wr_en & ~full;
      wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wr_acc};
      wgray_next = PW'(bin2gray(fifo_vec_t'(wbin_next)));
      rbin_s     = PW'(gray2bin(fifo_vec_t'(rq2)));
      full_cmp   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
      full_next  = (wgray_next == full_cmp);
      level_next = wbin_next - rbin_s;
      af_next    = (level_next >= AF_THRESH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin        <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wr_ptr_gray <= wgray_next;
         full        <= full_next;
         almost_full <= af_next;
         wr_level    <= level_next;
         // Set has priority over clear.
         overflow    <= (wr_en & full) | (overflow & ~clr_overflow);
      end
   end

   assign wr_addr = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_WIDTH=4, AF_MARGIN=2) with a queued expectation scoreboard.
module tb_fifo_wptr_full;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic       clr_overflow = 1'b0;
   logic [4:0] rd_ptr_gray = '0;
   logic [3:0] wr_addr;
   logic [4:0] wr_ptr_gray;
   logic       full;
   logic       almost_full;
   logic [4:0] wr_level;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] gray;
      logic       full;
      logic       af;
      logic [4:0] level;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];

   // Reference state: counts in plain binary, synchroniser as two delayed copies.
   int m_wcnt, m_rcnt, m_s1, m_s2, m_level;
   logic m_full, m_af, m_ovf;

   fifo_wptr_full #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .clr_overflow (clr_overflow),
      .rd_ptr_gray  (rd_ptr_gray),
      .wr_addr      (wr_addr),
      .wr_ptr_gray  (wr_ptr_gray),
      .full         (full),
      .almost_full  (almost_full),
      .wr_level     (wr_level),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wcnt = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic set_rd(input int r);
      m_rcnt      = r & 31;
      rd_ptr_gray = gray5(m_rcnt);
   endtask

   task automatic tick(input logic we, input logic clr);
      exp_t e, got;
      logic acc;
      wr_en        = we;
      clr_overflow = clr;
      chk("wr_addr", {28'd0, wr_addr}, m_wcnt & 15);
      acc     = we & ~m_full;
      m_ovf   = (we & m_full) | (m_ovf & ~clr);
      m_wcnt  = (m_wcnt + int'(acc)) & 31;
      m_level = (m_wcnt - m_s2) & 31;
      m_full  = (m_level == 16);
      m_af    = (m_level >= 14);
      m_s2    = m_s1;
      m_s1    = m_rcnt;
      e.gray = gray5(m_wcnt); e.full = m_full; e.af = m_af;
      e.level = m_level[4:0]; e.ovf = m_ovf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      clr_overflow = 1'b0;
      got = exp_q.pop_front();
      chk("wr_ptr_gray", {27'd0, wr_ptr_gray}, {27'd0, got.gray});
      chk("full", {31'd0, full}, {31'd0, got.full});
      chk("almost_full", {31'd0, almost_full}, {31'd0, got.af});
      chk("wr_level", {27'd0, wr_level}, {27'd0, got.level});
      chk("overflow", {31'd0, overflow}, {31'd0, got.ovf});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"}, {28'd0, wr_addr}, 0);
      chk({tag, "_gray"}, {27'd0, wr_ptr_gray}, 0);
      chk({tag, "_full"}, {31'd0, full}, 0);
      chk({tag, "_af"}, {31'd0, almost_full}, 0);
      chk({tag, "_level"}, {27'd0, wr_level}, 0);
      chk({tag, "_ovf"}, {31'd0, overflow}, 0);
   endtask

   // Assert reset away from the edge, check it bites before the next edge, release after 3 cycles.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      set_rd(0);
      #1;
      chk_all_zero({tag, "_async"});
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk_all_zero({tag, "_rel"});
   endtask

   initial begin
      logic [4:0] prev_gray;
      logic [3:0] prev_addr;
      bit saw_gray_wrap, saw_addr_wrap;
      model_reset();
      set_rd(0);

      // 1. Reset asserted mid-clock after some activity.
      @(posedge clk); #1;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      #2;
      do_reset("rst");

      // 2. Fill
      for (int i = 1; i <= 16; i++) begin
         tick(1'b1, 1'b0);
         if (i == 13) chk("af_before_14", {31'd0, almost_full}, 0);
         if (i == 14) begin
            chk("af_at_14", {31'd0, almost_full}, 1);
            chk("level_at_14", {27'd0, wr_level}, 14);
         end
         if (i == 15) chk("full_before_16", {31'd0, full}, 0);
      end
      chk("gray_after_16", {27'd0, wr_ptr_gray}, 32'h18);
      chk("full_at_16", {31'd0, full}, 1);
      chk("level_at_16", {27'd0, wr_level}, 16);

      // 3. Overflow
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      chk("ovf_addr_hold", {28'd0, wr_addr}, 0);
      chk("ovf_gray_hold", {27'd0, wr_ptr_gray}, 32'h18);
      chk("ovf_set", {31'd0, overflow}, 1);
      tick(1'b1, 1'b1);
      chk("ovf_set_wins", {31'd0, overflow}, 1);
      tick(1'b0, 1'b1);
      chk("ovf_cleared", {31'd0, overflow}, 0);

      // 4. Release by one read
      set_rd(1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("full_edge2", {31'd0, full}, 1);
      tick(1'b0, 1'b0);
      chk("full_edge3", {31'd0, full}, 0);
      chk("level_edge3", {27'd0, wr_level}, 15);
      tick(1'b1, 1'b0);
      chk("refull", {31'd0, full}, 1);

      // 5. Wrap with reads tracking writes
      set_rd(m_wcnt);
      repeat (3) tick(1'b0, 1'b0);
      chk("drained_full", {31'd0, full}, 0);
      saw_gray_wrap = 1'b0;
      saw_addr_wrap = 1'b0;
      for (int i = 0; i < 40; i++) begin
         prev_gray = wr_ptr_gray;
         prev_addr = wr_addr;
         tick(1'b1, 1'b0);
         chk("gray_onebit", $countones(prev_gray ^ wr_ptr_gray), 1);
         if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) saw_gray_wrap = 1'b1;
         if (prev_addr == 4'd15 && wr_addr == 4'd0) saw_addr_wrap = 1'b1;
         set_rd(m_wcnt);
      end
      chk("gray_wrap_seen", {31'd0, saw_gray_wrap}, 1);
      chk("addr_wrap_seen", {31'd0, saw_addr_wrap}, 1);

      // 6. Reset mid-stream
      do_reset("rst2");
      for (int i = 0; i < 9; i++) tick(1'b1, 1'b0);
      chk("addr_after_9", {28'd0, wr_addr}, 9);
      #2;
      do_reset("rst3");
      tick(1'b1, 1'b0);
      chk("addr_after_rst", {28'd0, wr_addr}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
